frame_buf_sched: RTL and testbench

FRAME_BUF_SCHED -- requirements
Module: frame_buf_sched

---
 rtl/frame_buf_sched.sv | 212 +++++++++++++++++++++
 tb/tb_frame_buf_sched.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_sched
// Brief    : Rotating DDR3 frame-buffer scheduler for one writer and one reader
//            driving an AXI burst master. Define FRAME_SCHED_REPEAT_EN to let
//            the reader re-read the last stored frame.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_sched #(
    parameter logic [31:0] BASE_ADRS    = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000,
    parameter logic [31:0] FRAME_LEN    = 32'h0020_0000,
    parameter int unsigned NUM_BUF      = 3
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        SCHED_CLR,
    input  logic        WR_REQ,
    input  logic        RD_REQ,
    output logic        WR_START,
    output logic [31:0] WR_ADRS,
    output logic [31:0] WR_LEN,
    input  logic        WR_READY,
    input  logic        WR_DONE,
    output logic        RD_START,
    output logic [31:0] RD_ADRS,
    output logic [31:0] RD_LEN,
    input  logic        RD_READY,
    input  logic        RD_DONE,
    output logic        WR_BUSY,
    output logic        RD_BUSY,
    output logic [1:0]  LATEST_IDX,
    output logic        FRAME_VALID
);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_START = 2'd1,
        W_BUSY  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_START = 2'd2,
        R_BUSY  = 2'd3
    } rd_state_t;

    localparam logic [2:0] c_num_buf = 3'(NUM_BUF);

    wr_state_t   r_wr_state_q, w_wr_state_d;
    rd_state_t   r_rd_state_q, w_rd_state_d;
    logic        r_pending_q, w_pending_d;
    logic        r_fresh_q, w_fresh_d;
    logic        r_frame_valid_q, w_frame_valid_d;
    logic        r_wr_start_q, w_wr_start_d;
    logic        r_rd_start_q, w_rd_start_d;
    logic [1:0]  r_wr_idx_q, w_wr_idx_d;
    logic [1:0]  r_rd_idx_q, w_rd_idx_d;
    logic [1:0]  r_latest_q, w_latest_d;
    logic [31:0] r_wr_adrs_q, w_wr_adrs_d;
    logic [31:0] r_rd_adrs_q, w_rd_adrs_d;

    logic        w_eligible;
    logic        w_rd_busy;
    logic [1:0]  w_rd_target;
    logic [1:0]  w_next_wr_idx;
    logic [2:0]  w_cand;
    logic        w_found;

    function automatic logic [31:0] buf_adrs(input logic [1:0] idx);
        return BASE_ADRS + ({30'd0, idx} * FRAME_STRIDE);
    endfunction

`ifdef FRAME_SCHED_REPEAT_EN
    assign w_eligible = r_frame_valid_q;
`else
    assign w_eligible = r_fresh_q;
`endif

    // In R_START the reader is about to latch LATEST_IDX, so that is the buffer to avoid.
    assign w_rd_busy   = (r_rd_state_q == R_START) || (r_rd_state_q == R_BUSY);
    assign w_rd_target = (r_rd_state_q == R_START) ? r_latest_q : r_rd_idx_q;

    always_comb begin
        w_next_wr_idx = r_wr_idx_q;
        w_found       = 1'b0;
        w_cand        = 3'd0;
        for (int i = 1; i < 4; i++) begin
            w_cand = {1'b0, r_wr_idx_q} + 3'(i);
            if (w_cand >= c_num_buf) w_cand = w_cand - c_num_buf;
            if (!w_found && (3'(i) < c_num_buf) &&
                !(w_rd_busy && (w_cand[1:0] == w_rd_target))) begin
                w_next_wr_idx = w_cand[1:0];
                w_found       = 1'b1;
            end
        end
    end

    always_comb begin
        w_wr_state_d    = r_wr_state_q;
        w_rd_state_d    = r_rd_state_q;
        w_pending_d     = r_pending_q;
        w_fresh_d       = r_fresh_q;
        w_frame_valid_d = r_frame_valid_q;
        w_wr_start_d    = 1'b0;
        w_rd_start_d    = 1'b0;
        w_wr_idx_d      = r_wr_idx_q;
        w_rd_idx_d      = r_rd_idx_q;
        w_latest_d      = r_latest_q;
        w_wr_adrs_d     = r_wr_adrs_q;
        w_rd_adrs_d     = r_rd_adrs_q;

        case (r_rd_state_q)
            R_IDLE:  if (RD_REQ) w_rd_state_d = R_WAIT;
            R_WAIT:  if (RD_READY && w_eligible) w_rd_state_d = R_START;
            R_START: begin
                w_rd_idx_d   = r_latest_q;
                w_rd_adrs_d  = buf_adrs(r_latest_q);
                w_rd_start_d = 1'b1;
                w_fresh_d    = 1'b0;
                w_rd_state_d = R_BUSY;
            end
            R_BUSY:  if (RD_DONE) w_rd_state_d = R_IDLE;
            default: w_rd_state_d = R_IDLE;
        endcase

        // Placed after the reader so a frame completing during R_START stays fresh.
        case (r_wr_state_q)
            W_IDLE: begin
                if ((WR_REQ || r_pending_q) && WR_READY) begin
                    w_wr_state_d = W_START;
                    w_pending_d  = 1'b0;
                end else if (WR_REQ) begin
                    w_pending_d = 1'b1;
                end
            end
            W_START: begin
                w_wr_start_d = 1'b1;
                w_wr_adrs_d  = buf_adrs(r_wr_idx_q);
                w_wr_state_d = W_BUSY;
                if (WR_REQ) w_pending_d = 1'b1;
            end
            W_BUSY: begin
                if (WR_REQ) w_pending_d = 1'b1;
                if (WR_DONE) begin
                    w_latest_d      = r_wr_idx_q;
                    w_frame_valid_d = 1'b1;
                    w_fresh_d       = 1'b1;
                    w_wr_idx_d      = w_next_wr_idx;
                    w_wr_state_d    = W_IDLE;
                end
            end
            default: w_wr_state_d = W_IDLE;
        endcase

        if (SCHED_CLR) begin
            w_wr_state_d    = W_IDLE;
            w_rd_state_d    = R_IDLE;
            w_pending_d     = 1'b0;
            w_fresh_d       = 1'b0;
            w_frame_valid_d = 1'b0;
            w_wr_start_d    = 1'b0;
            w_rd_start_d    = 1'b0;
            w_wr_idx_d      = 2'd0;
            w_latest_d      = 2'd0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_state_q    <= W_IDLE;
            r_rd_state_q    <= R_IDLE;
            r_pending_q     <= 1'b0;
            r_fresh_q       <= 1'b0;
            r_frame_valid_q <= 1'b0;
            r_wr_start_q    <= 1'b0;
            r_rd_start_q    <= 1'b0;
            r_wr_idx_q      <= 2'd0;
            r_rd_idx_q      <= 2'd0;
            r_latest_q      <= 2'd0;
            r_wr_adrs_q     <= BASE_ADRS;
            r_rd_adrs_q     <= BASE_ADRS;
        end else begin
            r_wr_state_q    <= w_wr_state_d;
            r_rd_state_q    <= w_rd_state_d;
            r_pending_q     <= w_pending_d;
            r_fresh_q       <= w_fresh_d;
            r_frame_valid_q <= w_frame_valid_d;
            r_wr_start_q    <= w_wr_start_d;
            r_rd_start_q    <= w_rd_start_d;
            r_wr_idx_q      <= w_wr_idx_d;
            r_rd_idx_q      <= w_rd_idx_d;
            r_latest_q      <= w_latest_d;
            r_wr_adrs_q     <= w_wr_adrs_d;
            r_rd_adrs_q     <= w_rd_adrs_d;
        end
    end

    assign WR_START    = r_wr_start_q;
    assign RD_START    = r_rd_start_q;
    assign WR_ADRS     = r_wr_adrs_q;
    assign RD_ADRS     = r_rd_adrs_q;
    assign WR_LEN      = FRAME_LEN;
    assign RD_LEN      = FRAME_LEN;
    assign WR_BUSY     = (r_wr_state_q != W_IDLE);
    assign RD_BUSY     = w_rd_busy;
    assign LATEST_IDX  = r_latest_q;
    assign FRAME_VALID = r_frame_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buf_sched
// Brief    : Self-checking bench for frame_buf_sched: directed scenarios plus a
//            randomized transaction sequence scored against a buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buf_sched;

    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] STRIDE = 32'h0080_0000;
    localparam logic [31:0] LEN    = 32'h0020_0000;
    localparam int          NBUF   = 3;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        SCHED_CLR = 1'b0;
    logic        WR_REQ = 1'b0;
    logic        RD_REQ = 1'b0;
    logic        WR_READY = 1'b1;
    logic        WR_DONE = 1'b0;
    logic        RD_READY = 1'b1;
    logic        RD_DONE = 1'b0;
    logic        WR_START, RD_START, WR_BUSY, RD_BUSY, FRAME_VALID;
    logic [31:0] WR_ADRS, WR_LEN, RD_ADRS, RD_LEN;
    logic [1:0]  LATEST_IDX;

    int errors = 0;
    int checks = 0;

    // Reference model state: which buffer the writer targets next, which holds
    // the newest frame, and which one the reader currently owns.
    int m_wr, m_latest, m_rd;
    bit m_valid, m_fresh, m_reading;

    always #5 ACLK = ~ACLK;

    frame_buf_sched #(
        .BASE_ADRS   (BASE),
        .FRAME_STRIDE(STRIDE),
        .FRAME_LEN   (LEN),
        .NUM_BUF     (NBUF)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .SCHED_CLR  (SCHED_CLR),
        .WR_REQ     (WR_REQ),
        .RD_REQ     (RD_REQ),
        .WR_START   (WR_START),
        .WR_ADRS    (WR_ADRS),
        .WR_LEN     (WR_LEN),
        .WR_READY   (WR_READY),
        .WR_DONE    (WR_DONE),
        .RD_START   (RD_START),
        .RD_ADRS    (RD_ADRS),
        .RD_LEN     (RD_LEN),
        .RD_READY   (RD_READY),
        .RD_DONE    (RD_DONE),
        .WR_BUSY    (WR_BUSY),
        .RD_BUSY    (RD_BUSY),
        .LATEST_IDX (LATEST_IDX),
        .FRAME_VALID(FRAME_VALID)
    );

    function automatic logic [31:0] m_adrs(input int idx);
        logic [31:0] p;
        p = 32'(idx) * STRIDE;
        return BASE + p;
    endfunction

    function automatic bit m_eligible();
`ifdef FRAME_SCHED_REPEAT_EN
        return m_valid;
`else
        return m_fresh;
`endif
    endfunction

    // A completed write becomes the newest frame; the writer moves to the next
    // buffer in rotation that is neither that frame nor the one being read.
    task automatic m_write_done();
        int old;
        old      = m_wr;
        m_latest = old;
        m_valid  = 1'b1;
        m_fresh  = 1'b1;
        for (int k = 1; k < NBUF; k++) begin
            if (((old + k) % NBUF) != m_latest &&
                !(m_reading && ((old + k) % NBUF) == m_rd)) begin
                m_wr = (old + k) % NBUF;
                break;
            end
        end
    endtask

    task automatic do_reset();
        ARESETN = 1'b0; SCHED_CLR = 1'b0; WR_REQ = 1'b0; RD_REQ = 1'b0;
        WR_DONE = 1'b0; RD_DONE = 1'b0; WR_READY = 1'b1; RD_READY = 1'b1;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        m_wr = 0; m_latest = 0; m_rd = 0;
        m_valid = 1'b0; m_fresh = 1'b0; m_reading = 1'b0;
    endtask

    task automatic pulse_wr_req();
        @(negedge ACLK); WR_REQ = 1'b1;
        @(negedge ACLK); WR_REQ = 1'b0;
    endtask

    task automatic pulse_rd_req();
        @(negedge ACLK); RD_REQ = 1'b1;
        @(negedge ACLK); RD_REQ = 1'b0;
    endtask

    task automatic pulse_wr_done();
        @(negedge ACLK); WR_DONE = 1'b1;
        @(negedge ACLK); WR_DONE = 1'b0;
    endtask

    task automatic pulse_rd_done();
        @(negedge ACLK); RD_DONE = 1'b1;
        @(negedge ACLK); RD_DONE = 1'b0;
    endtask

    task automatic wait_wr_start(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge ACLK);
            if (WR_START) begin seen = 1'b1; break; end
        end
    endtask

    task automatic wait_rd_start(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge ACLK);
            if (RD_START) begin seen = 1'b1; break; end
        end
    endtask

    // Full write transaction; the address seen with WR_START is returned.
    task automatic do_write(output logic [31:0] adrs, output bit seen);
        pulse_wr_req();
        wait_wr_start(20, seen);
        adrs = WR_ADRS;
        if (seen) begin
            repeat ($urandom_range(0, 2)) @(negedge ACLK);
            pulse_wr_done();
        end
    endtask

    task automatic do_read_start(output logic [31:0] adrs, output bit seen);
        pulse_rd_req();
        wait_rd_start(20, seen);
        adrs = RD_ADRS;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        bit s;
        do_reset();
        checks++;
        if (WR_START !== 1'b0 || RD_START !== 1'b0 || WR_BUSY !== 1'b0 || RD_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got wr_start=%b rd_start=%b wr_busy=%b rd_busy=%b, want all 0",
                     WR_START, RD_START, WR_BUSY, RD_BUSY);
        end
        checks++;
        if (WR_LEN !== LEN || RD_LEN !== LEN) begin
            errors++;
            $display("FAIL reset_len: got wr=%h rd=%h, want %h", WR_LEN, RD_LEN, LEN);
        end
        do_write(a, s);
        pulse_wr_req();
        wait_wr_start(20, s);
        checks++;
        if (!s || WR_ADRS !== 32'h0080_0000 || WR_BUSY !== 1'b1 || FRAME_VALID !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_write: seen=%b adrs=%h busy=%b valid=%b, want 1 00800000 1 1",
                     s, WR_ADRS, WR_BUSY, FRAME_VALID);
        end
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if (WR_BUSY !== 1'b0 || WR_START !== 1'b0 || WR_ADRS !== BASE || RD_ADRS !== BASE ||
            LATEST_IDX !== 2'd0 || FRAME_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: busy=%b start=%b wadrs=%h radrs=%h latest=%0d valid=%b, want 0 0 %h %h 0 0",
                     WR_BUSY, WR_START, WR_ADRS, RD_ADRS, LATEST_IDX, FRAME_VALID, BASE, BASE);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        pulse_wr_done();
        pulse_rd_done();
        checks++;
        if (FRAME_VALID !== 1'b0 || LATEST_IDX !== 2'd0 || WR_BUSY !== 1'b0 || RD_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_done: valid=%b latest=%0d wbusy=%b rbusy=%b, want 0 0 0 0",
                     FRAME_VALID, LATEST_IDX, WR_BUSY, RD_BUSY);
        end
    endtask

    task automatic test_write_latency();
        do_reset();
        @(negedge ACLK); WR_REQ = 1'b1;
        @(negedge ACLK); WR_REQ = 1'b0;
        checks++;
        if (WR_START !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: wr_start=%b after 1 cycle, want 0", WR_START);
        end
        @(negedge ACLK);
        checks++;
        if (WR_START !== 1'b1 || WR_ADRS !== BASE || WR_LEN !== 32'h0020_0000) begin
            errors++;
            $display("FAIL lat_start: start=%b adrs=%h len=%h, want 1 %h 00200000",
                     WR_START, WR_ADRS, WR_LEN, BASE);
        end
        @(negedge ACLK);
        checks++;
        if (WR_START !== 1'b0 || WR_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL lat_one_cycle: start=%b busy=%b, want 0 1", WR_START, WR_BUSY);
        end
        pulse_wr_done();
        checks++;
        if (LATEST_IDX !== 2'd0 || FRAME_VALID !== 1'b1 || WR_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL lat_done: latest=%0d valid=%b busy=%b, want 0 1 0",
                     LATEST_IDX, FRAME_VALID, WR_BUSY);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        logic [31:0] a;
        bit s;
        exp[0] = 32'h0000_0000; exp[1] = 32'h0080_0000; exp[2] = 32'h0100_0000;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_write(a, s);
            checks++;
            if (!s || a !== exp[i]) begin
                errors++;
                $display("FAIL b2b_adrs[%0d]: seen=%b adrs=%h, want %h", i, s, a, exp[i]);
            end
        end
        checks++;
        if (LATEST_IDX !== 2'd2) begin
            errors++;
            $display("FAIL b2b_latest: got %0d, want 2", LATEST_IDX);
        end
    endtask

    task automatic test_read_protect();
        logic [31:0] a;
        bit s;
        do_reset();
        do_write(a, s);
        do_read_start(a, s);
        checks++;
        if (!s || a !== BASE) begin
            errors++;
            $display("FAIL prot_rd_adrs: seen=%b adrs=%h, want %h", s, a, BASE);
        end
        do_write(a, s);
        checks++;
        if (!s || a !== 32'h0080_0000) begin
            errors++;
            $display("FAIL prot_wr1: seen=%b adrs=%h, want 00800000", s, a);
        end
        do_write(a, s);
        checks++;
        if (!s || a !== 32'h0100_0000 || RD_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL prot_wr2: seen=%b adrs=%h rd_busy=%b, want 01000000 busy 1", s, a, RD_BUSY);
        end
        do_write(a, s);
        checks++;
        if (!s || a !== 32'h0080_0000) begin
            errors++;
            $display("FAIL prot_wr3: seen=%b adrs=%h, want 00800000 (buffer 0 still read)", s, a);
        end
        pulse_rd_done();
    endtask

    task automatic test_repeat();
        logic [31:0] a;
        bit s;
        do_reset();
        do_write(a, s);
        do_read_start(a, s);
        pulse_rd_done();
        pulse_rd_req();
`ifdef FRAME_SCHED_REPEAT_EN
        wait_rd_start(20, s);
        checks++;
        if (!s || RD_ADRS !== BASE) begin
            errors++;
            $display("FAIL repeat_reissue: seen=%b adrs=%h, want 1 %h", s, RD_ADRS, BASE);
        end
`else
        wait_rd_start(12, s);
        checks++;
        if (s) begin
            errors++;
            $display("FAIL repeat_hold: rd_start seen=%b without new frame, want 0", s);
        end
        do_write(a, s);
        wait_rd_start(20, s);
        checks++;
        if (!s || RD_ADRS !== 32'h0080_0000) begin
            errors++;
            $display("FAIL repeat_after_write: seen=%b adrs=%h, want 1 00800000", s, RD_ADRS);
        end
`endif
        pulse_rd_done();
    endtask

    task automatic test_pending();
        int cnt;
        logic [31:0] a2;
        bit s;
        do_reset();
        pulse_wr_req();
        wait_wr_start(20, s);
        repeat (3) pulse_wr_req();
        pulse_wr_done();
        cnt = 0;
        a2  = 32'hxxxx_xxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (WR_START) begin cnt++; a2 = WR_ADRS; end
        end
        checks++;
        if (cnt != 1 || a2 !== 32'h0080_0000) begin
            errors++;
            $display("FAIL pending_once: starts=%0d adrs=%h, want 1 00800000", cnt, a2);
        end
        pulse_wr_done();
        repeat (5) @(negedge ACLK);
        checks++;
        if (WR_BUSY !== 1'b0 || LATEST_IDX !== 2'd1) begin
            errors++;
            $display("FAIL pending_drain: busy=%b latest=%0d, want 0 1", WR_BUSY, LATEST_IDX);
        end
    endtask

    task automatic test_clear();
        logic [31:0] a;
        bit s;
        do_reset();
        do_write(a, s);
        RD_READY = 1'b0;
        pulse_rd_req();
        repeat (2) @(negedge ACLK);
        SCHED_CLR = 1'b1;
        @(negedge ACLK);
        SCHED_CLR = 1'b0;
        checks++;
        if (FRAME_VALID !== 1'b0 || LATEST_IDX !== 2'd0 || RD_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: valid=%b latest=%0d rd_busy=%b, want 0 0 0",
                     FRAME_VALID, LATEST_IDX, RD_BUSY);
        end
        RD_READY = 1'b1;
        wait_rd_start(12, s);
        checks++;
        if (s) begin
            errors++;
            $display("FAIL clear_no_read: rd_start seen=%b, want 0", s);
        end
        do_write(a, s);
        checks++;
        if (!s || a !== BASE) begin
            errors++;
            $display("FAIL clear_wr_idx: seen=%b adrs=%h, want 1 %h", s, a, BASE);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit s;
        int op;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_write(a, s);
                checks++;
                if (!s || a !== m_adrs(m_wr)) begin
                    errors++;
                    $display("FAIL rnd_wr_adrs[%0d]: seen=%b adrs=%h, want %h", n, s, a, m_adrs(m_wr));
                end
                m_write_done();
                checks++;
                if (LATEST_IDX !== 2'(m_latest) || FRAME_VALID !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_latest[%0d]: latest=%0d valid=%b, want %0d 1",
                             n, LATEST_IDX, FRAME_VALID, m_latest);
                end
            end else if (op == 1 && !m_reading && m_eligible()) begin
                RD_READY = 1'($urandom_range(0, 1));
                pulse_rd_req();
                if (!RD_READY) begin
                    repeat ($urandom_range(1, 4)) @(negedge ACLK);
                    RD_READY = 1'b1;
                end
                wait_rd_start(20, s);
                checks++;
                if (!s || RD_ADRS !== m_adrs(m_latest)) begin
                    errors++;
                    $display("FAIL rnd_rd_adrs[%0d]: seen=%b adrs=%h, want %h",
                             n, s, RD_ADRS, m_adrs(m_latest));
                end
                m_reading = 1'b1;
                m_rd      = m_latest;
                m_fresh   = 1'b0;
            end else if (op == 2 && m_reading) begin
                repeat ($urandom_range(0, 3)) @(negedge ACLK);
                pulse_rd_done();
                m_reading = 1'b0;
                checks++;
                if (RD_BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_rd_idle[%0d]: rd_busy=%b, want 0", n, RD_BUSY);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_latency();
        test_back_to_back();
        test_read_protect();
        test_repeat();
        test_pending();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
